// File: rtl/f_d_pipe_reg.sv
// f_d_pipe_reg: F/D pipeline register with fetch address-error (AdEL) detection
module f_d_pipe_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_TOP     = 32'h0000_6FFC,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        stall,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  input  logic        f_bd,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [4:0]  d_exc_code,
  output logic        d_bd,
  output logic        d_valid
);
  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic [4:0]  exc_q, exc_d;
  logic        bd_q, bd_d, valid_q, valid_d, fault;
  // flush beats stall, stall beats capture; a faulting fetch keeps its PC for EPC/BadVAddr
  always_comb begin
    fault   = (f_pc[1:0] != 2'b00) || (f_pc < IM_BASE) || (f_pc > IM_TOP);
    pc_d    = req ? HANDLER_PC : stall ? pc_q : f_pc;
    instr_d = req ? 32'd0 : stall ? instr_q : fault ? 32'd0 : f_instr;
    exc_d   = req ? 5'd0 : stall ? exc_q : fault ? EXC_ADEL : 5'd0;
    bd_d    = req ? 1'b0 : stall ? bd_q : f_bd;
    valid_d = req ? 1'b0 : stall ? valid_q : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      exc_q   <= 5'd0;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
      valid_q <= valid_d;
    end
  end
  assign d_pc       = pc_q;
  assign d_instr    = instr_q;
  assign d_exc_code = exc_q;
  assign d_bd       = bd_q;
  assign d_valid    = valid_q;
endmodule

// File: tb/tb_f_d_pipe_reg.sv
// tb_f_d_pipe_reg: directed checks of the F/D pipeline register
module tb_f_d_pipe_reg;
  logic        clk = 1'b0;
  logic        reset, req, stall, f_bd;
  logic [31:0] f_pc, f_instr;
  logic [31:0] d_pc, d_instr;
  logic [4:0]  d_exc_code;
  logic        d_bd, d_valid;
  int checks = 0;
  int errors = 0;
  f_d_pipe_reg dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall),
    .f_pc(f_pc), .f_instr(f_instr), .f_bd(f_bd),
    .d_pc(d_pc), .d_instr(d_instr), .d_exc_code(d_exc_code),
    .d_bd(d_bd), .d_valid(d_valid)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] exc, input logic bd, input logic valid);
    chk({tag, ".pc"}, d_pc, pc);
    chk({tag, ".instr"}, d_instr, instr);
    chk({tag, ".exc"}, {27'd0, d_exc_code}, {27'd0, exc});
    chk({tag, ".bd"}, {31'd0, d_bd}, {31'd0, bd});
    chk({tag, ".valid"}, {31'd0, d_valid}, {31'd0, valid});
  endtask
  initial begin
    reset = 1; req = 0; stall = 0; f_bd = 0;
    f_pc = 32'h0000_3010; f_instr = 32'hDEAD_BEEF;
    tick();
    chk_all("reset", 32'h3000, 0, 0, 0, 0);
    reset = 0; f_pc = 32'h3004; f_instr = 32'h3C01_1234; f_bd = 1;
    tick();
    chk_all("capture", 32'h3004, 32'h3C01_1234, 0, 1, 1);
    stall = 1; f_pc = 32'h3008; f_instr = 32'hAAAA_5555; f_bd = 0;
    tick();
    chk_all("stall1", 32'h3004, 32'h3C01_1234, 0, 1, 1);
    f_pc = 32'h300C; f_instr = 32'h1234_5678;
    tick();
    chk_all("stall2", 32'h3004, 32'h3C01_1234, 0, 1, 1);
    f_pc = 32'h3008; f_instr = 32'hAAAA_5555;
    tick();
    chk_all("stall3", 32'h3004, 32'h3C01_1234, 0, 1, 1);
    stall = 0;
    tick();
    chk_all("unstall", 32'h3008, 32'hAAAA_5555, 0, 0, 1);
    f_pc = 32'h3002; f_instr = 32'h1111_1111;
    tick();
    chk_all("misalign", 32'h3002, 0, 4, 0, 1);
    f_pc = 32'h7000; f_instr = 32'h2222_2222; f_bd = 1;
    tick();
    chk_all("above_top", 32'h7000, 0, 4, 1, 1);
    f_pc = 32'h6FFC; f_instr = 32'h2222_3333; f_bd = 0;
    tick();
    chk_all("top_edge", 32'h6FFC, 32'h2222_3333, 0, 0, 1);
    f_pc = 32'h3000; f_instr = 32'h0800_0C00;
    tick();
    chk_all("base_edge", 32'h3000, 32'h0800_0C00, 0, 0, 1);
    f_pc = 32'hFFFF_3000; f_instr = 32'h4444_4444;
    tick();
    chk_all("alias", 32'hFFFF_3000, 0, 4, 0, 1);
    f_pc = 32'h2FFC; f_instr = 32'h5555_5555; f_bd = 1;
    tick();
    chk_all("below_base", 32'h2FFC, 0, 4, 1, 1);
    stall = 1; f_pc = 32'h3010; f_instr = 32'h6666_6666; f_bd = 0;
    tick();
    chk_all("stall_fault", 32'h2FFC, 0, 4, 1, 1);
    req = 1;
    tick();
    chk_all("req_stall", 32'h4180, 0, 0, 0, 0);
    req = 0; stall = 0;
    tick();
    chk_all("post_req", 32'h3010, 32'h6666_6666, 0, 0, 1);
    reset = 1; req = 1; f_pc = 32'h7001;
    tick();
    chk_all("reset_req", 32'h3000, 0, 0, 0, 0);
    reset = 0; req = 0; f_pc = 32'h3020; f_instr = 32'h7777_7777; f_bd = 1;
    tick();
    chk_all("recap", 32'h3020, 32'h7777_7777, 0, 1, 1);
    stall = 1; reset = 1;
    tick();
    chk_all("reset_stall", 32'h3000, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
